// File: rtl/spgd_iter_sequencer.sv
// SPGD iteration sequencer: +sigma / -sigma perturbation, settle, metric averaging,
// and valid/ready hand-off of J+, J- and dJ to the gradient-update stage.
module spgd_iter_sequencer #(
    parameter int unsigned ADC_WIDTH = 12,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned MAX_LOG2  = 12
) (
    input  logic                 ADC_CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [CNT_WIDTH-1:0] SETTLE_CYC,
    input  logic [3:0]           AVE_LOG2,
    input  logic [ADC_WIDTH-1:0] SAMPLE_IN,
    output logic                 PERT_STB,
    output logic                 PERT_SIGN,
    output logic [ADC_WIDTH-1:0] J_PLUS,
    output logic [ADC_WIDTH-1:0] J_MINUS,
    output logic [ADC_WIDTH:0]   DELTA_J,
    output logic                 UPD_VALID,
    input  logic                 UPD_READY,
    output logic                 BUSY,
    output logic [31:0]          ITER_CNT
);

    localparam int unsigned ACC_W = ADC_WIDTH + MAX_LOG2;
    localparam int unsigned WIN_W = MAX_LOG2 + 1;
    localparam int unsigned CW    = (CNT_WIDTH > WIN_W) ? CNT_WIDTH : WIN_W;
    localparam int unsigned LW    = 4;
    localparam int unsigned DJ_W  = ADC_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPLY_P  = 3'd1,
        S_SETTLE_P = 3'd2,
        S_ACC_P    = 3'd3,
        S_APPLY_M  = 3'd4,
        S_SETTLE_M = 3'd5,
        S_ACC_M    = 3'd6,
        S_UPDATE   = 3'd7
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_WIDTH-1:0] settle_q, settle_d;
    logic [LW-1:0]        log2_q, log2_d;
    logic [ADC_WIDTH-1:0] j_plus_q, j_plus_d;
    logic [ADC_WIDTH-1:0] j_minus_q, j_minus_d;
    logic [DJ_W-1:0]      delta_q, delta_d;
    logic [31:0]          iter_q, iter_d;
    logic                 stb_q, stb_d;
    logic                 sign_q, sign_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;

    logic [CNT_WIDTH-1:0] settle_eff;
    logic [LW-1:0]        log2_clamp;
    logic [LW-1:0]        log2_eff;
    logic [CW-1:0]        win_last;
    logic [ACC_W-1:0]     acc_sum;
    logic [ADC_WIDTH-1:0] avg;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        settle_d  = settle_q;
        log2_d    = log2_q;
        j_plus_d  = j_plus_q;
        j_minus_d = j_minus_q;
        delta_d   = delta_q;
        iter_d    = iter_q;
        sign_d    = sign_q;
        stb_d     = 1'b0;
        busy_d    = 1'b0;
        valid_d   = 1'b0;

        log2_clamp = (32'(AVE_LOG2) > MAX_LOG2) ? LW'(MAX_LOG2) : AVE_LOG2;
        // Config is sampled in APPLY_P, so that cycle uses the live inputs
        settle_eff = (state_q == S_APPLY_P) ? SETTLE_CYC : settle_q;
        log2_eff   = (state_q == S_APPLY_P) ? log2_clamp : log2_q;
        win_last   = CW'((CW'(1) << log2_eff) - CW'(1));
        acc_sum    = acc_q + ACC_W'(SAMPLE_IN);
        avg        = ADC_WIDTH'(acc_sum >> log2_q);

        unique case (state_q)
            S_IDLE: begin
                if (EN) state_d = S_APPLY_P;
            end
            S_APPLY_P, S_APPLY_M: begin
                if (state_q == S_APPLY_P) begin
                    settle_d = SETTLE_CYC;
                    log2_d   = log2_clamp;
                end
                acc_d = '0;
                if (settle_eff == '0) begin
                    state_d = (state_q == S_APPLY_P) ? S_ACC_P : S_ACC_M;
                    cnt_d   = win_last;
                end else begin
                    state_d = (state_q == S_APPLY_P) ? S_SETTLE_P : S_SETTLE_M;
                    cnt_d   = CW'(settle_eff) - CW'(1);
                end
            end
            S_SETTLE_P, S_SETTLE_M: begin
                if (cnt_q == '0) begin
                    state_d = (state_q == S_SETTLE_P) ? S_ACC_P : S_ACC_M;
                    cnt_d   = win_last;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACC_P, S_ACC_M: begin
                acc_d = acc_sum;
                if (cnt_q == '0) begin
                    acc_d = '0;
                    if (state_q == S_ACC_P) begin
                        j_plus_d = avg;
                        state_d  = S_APPLY_M;
                    end else begin
                        j_minus_d = avg;
                        delta_d   = {1'b0, j_plus_q} - {1'b0, avg};
                        state_d   = S_UPDATE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_UPDATE: begin
                if (UPD_READY) begin
                    iter_d  = iter_q + 32'd1;
                    state_d = EN ? S_APPLY_P : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort: drop the iteration, keep the last published results
        if (!EN && state_q != S_IDLE && state_q != S_UPDATE) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            acc_d     = '0;
            j_plus_d  = j_plus_q;
            j_minus_d = j_minus_q;
            delta_d   = delta_q;
        end

        stb_d   = (state_d == S_APPLY_P) || (state_d == S_APPLY_M);
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_UPDATE);
        if (state_d == S_APPLY_P) sign_d = 1'b0;
        if (state_d == S_APPLY_M) sign_d = 1'b1;
    end

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            settle_q  <= '0;
            log2_q    <= '0;
            j_plus_q  <= '0;
            j_minus_q <= '0;
            delta_q   <= '0;
            iter_q    <= '0;
            stb_q     <= 1'b0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            settle_q  <= settle_d;
            log2_q    <= log2_d;
            j_plus_q  <= j_plus_d;
            j_minus_q <= j_minus_d;
            delta_q   <= delta_d;
            iter_q    <= iter_d;
            stb_q     <= stb_d;
            sign_q    <= sign_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign PERT_STB  = stb_q;
    assign PERT_SIGN = sign_q;
    assign J_PLUS    = j_plus_q;
    assign J_MINUS   = j_minus_q;
    assign DELTA_J   = delta_q;
    assign UPD_VALID = valid_q;
    assign BUSY      = busy_q;
    assign ITER_CNT  = iter_q;

endmodule

// File: tb/tb_spgd_iter_sequencer.sv
// Directed bench for spgd_iter_sequencer: a vector table of single iterations plus
// hand-written sequences for back-pressure, abort, reset and back-to-back operation.
module tb_spgd_iter_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] settle_cyc;
    logic [3:0]  ave_log2;
    logic [11:0] sample_in;
    logic        pert_stb;
    logic        pert_sign;
    logic [11:0] j_plus;
    logic [11:0] j_minus;
    logic [12:0] delta_j;
    logic        upd_valid;
    logic        upd_ready;
    logic        busy;
    logic [31:0] iter_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_iter = 0;

    // Sample source: two-level toggling pattern per perturbation sign
    logic        tog = 1'b0;
    logic [11:0] p_lo, p_hi, m_lo, m_hi;
    always @(posedge clk) tog <= ~tog;
    assign sample_in = pert_sign ? (tog ? m_hi : m_lo) : (tog ? p_hi : p_lo);

    always #5 clk = ~clk;

    spgd_iter_sequencer #(.ADC_WIDTH(12), .CNT_WIDTH(16), .MAX_LOG2(12)) dut (
        .ADC_CLK   (clk),
        .RST       (rst),
        .EN        (en),
        .SETTLE_CYC(settle_cyc),
        .AVE_LOG2  (ave_log2),
        .SAMPLE_IN (sample_in),
        .PERT_STB  (pert_stb),
        .PERT_SIGN (pert_sign),
        .J_PLUS    (j_plus),
        .J_MINUS   (j_minus),
        .DELTA_J   (delta_j),
        .UPD_VALID (upd_valid),
        .UPD_READY (upd_ready),
        .BUSY      (busy),
        .ITER_CNT  (iter_cnt)
    );

    typedef struct {
        logic [15:0] settle;
        logic [3:0]  ave;
        logic [11:0] plo, phi, mlo, mhi;
        logic [11:0] ejp, ejm;
        logic [12:0] edj;
        int          elen;
    } vec_t;

    vec_t vecs[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_pat(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] c, input logic [11:0] d);
        p_lo = a; p_hi = b; m_lo = c; m_hi = d;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int nv;
        logic seen;

        //               settle ave  plo     phi     mlo     mhi     ejp     ejm     edj       len
        vecs[0] = '{16'd4, 4'd3,  12'd100, 12'd100, 12'd60,  12'd60,  12'd100, 12'd60,  13'd40,   27};
        vecs[1] = '{16'd0, 4'd0,  12'd5,   12'd5,   12'd9,   12'd9,   12'd5,   12'd9,   13'h1FFC, 5};
        vecs[2] = '{16'd2, 4'd1,  12'd10,  12'd13,  12'd0,   12'd1,   12'd11,  12'd0,   13'd11,   11};
        vecs[3] = '{16'd1, 4'd2,  12'hFFF, 12'hFFF, 12'd0,   12'd0,   12'hFFF, 12'd0,   13'h0FFF, 13};
        vecs[4] = '{16'd3, 4'd4,  12'd7,   12'd8,   12'd200, 12'd301, 12'd7,   12'd250, 13'd7949, 41};
        vecs[5] = '{16'd4, 4'd15, 12'd0,   12'd0,   12'hFFF, 12'hFFF, 12'd0,   12'hFFF, 13'h1001, 8203};
        vecs[6] = '{16'd0, 4'd13, 12'd1000,12'd1001,12'd3,   12'd3,   12'd1000,12'd3,   13'd997,  8195};

        // Reset with EN already high
        rst = 1'b1; en = 1'b1; upd_ready = 1'b1;
        settle_cyc = 16'd4; ave_log2 = 4'd3;
        set_pat(12'd0, 12'd0, 12'd0, 12'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_outs", {pert_stb, pert_sign, upd_valid, 29'd0} | 32'(j_plus) | 32'(j_minus)
                  | 32'(delta_j) | iter_cnt, 32'd0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_stb", 32'(pert_stb), 32'd1);
        check("post_rst_sign", 32'(pert_sign), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd1);
        en = 1'b0;
        tick();
        check("abort_apply_busy", 32'(busy), 32'd0);
        check("abort_apply_iter", iter_cnt, 32'd0);

        // Table: one iteration per vector, EN dropped during UPDATE
        foreach (vecs[v]) begin
            settle_cyc = vecs[v].settle;
            ave_log2   = vecs[v].ave;
            set_pat(vecs[v].plo, vecs[v].phi, vecs[v].mlo, vecs[v].mhi);
            upd_ready = 1'b1;
            en = 1'b1;
            tick();
            c = 1;
            check($sformatf("v%0d_stb", v), {31'd0, pert_stb & ~pert_sign}, 32'd1);
            while (!upd_valid && c < 20000) begin
                tick();
                c++;
            end
            check($sformatf("v%0d_len", v), 32'(c), 32'(vecs[v].elen));
            check($sformatf("v%0d_jp", v), 32'(j_plus), 32'(vecs[v].ejp));
            check($sformatf("v%0d_jm", v), 32'(j_minus), 32'(vecs[v].ejm));
            check($sformatf("v%0d_dj", v), 32'(delta_j), 32'(vecs[v].edj));
            en = 1'b0;
            tick();
            exp_iter++;
            check($sformatf("v%0d_iter", v), iter_cnt, 32'(exp_iter));
            check($sformatf("v%0d_idle", v), {30'd0, busy, upd_valid}, 32'd0);
        end

        // Back-to-back length with EN held: APPLY_P to next APPLY_P is 27 cycles
        settle_cyc = 16'd4; ave_log2 = 4'd3;
        set_pat(12'd100, 12'd100, 12'd60, 12'd60);
        en = 1'b1;
        tick();
        c = 0; nv = 0;
        do begin
            tick();
            c++;
            if (upd_valid) nv++;
        end while (!(pert_stb && !pert_sign) && c < 1000);
        check("iter_len", 32'(c), 32'd27);
        check("iter_valid_cycles", 32'(nv), 32'd1);
        en = 1'b0;
        tick();
        exp_iter++;
        check("iter_len_cnt", iter_cnt, 32'(exp_iter));
        check("iter_len_idle", 32'(busy), 32'd0);

        // READY held low in UPDATE: output held, single increment on accept
        settle_cyc = 16'd1; ave_log2 = 4'd1;
        set_pat(12'd50, 12'd50, 12'd20, 12'd20);
        upd_ready = 1'b0;
        en = 1'b1;
        c = 0;
        while (!upd_valid && c < 1000) begin
            tick();
            c++;
        end
        check("bp_len", 32'(c), 32'd9);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(upd_valid), 32'd1);
            check("bp_data", {7'd0, j_plus, delta_j}, {7'd0, 12'd50, 13'd30});
            check("bp_iter", iter_cnt, 32'(exp_iter));
            tick();
        end
        upd_ready = 1'b1;
        en = 1'b0;
        tick();
        exp_iter++;
        check("bp_accept_iter", iter_cnt, 32'(exp_iter));
        check("bp_accept_idle", {30'd0, busy, upd_valid}, 32'd0);
        check("bp_accept_jm", 32'(j_minus), 32'd20);

        // EN dropped in SETTLE_M
        settle_cyc = 16'd6; ave_log2 = 4'd1;
        set_pat(12'd33, 12'd33, 12'd77, 12'd77);
        en = 1'b1;
        c = 0;
        do begin
            tick();
            c++;
        end while (!(pert_stb && pert_sign) && c < 1000);
        check("abort_find_apply_m", 32'(c), 32'd10);
        tick();
        en = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(upd_valid), 32'd0);
        check("abort_iter", iter_cnt, 32'(exp_iter));
        check("abort_jp", 32'(j_plus), 32'd33);
        check("abort_jm", 32'(j_minus), 32'd20);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | upd_valid | pert_stb;
        end
        check("abort_quiet", 32'(seen), 32'd0);

        // RST during ACC_P
        settle_cyc = 16'd0; ave_log2 = 4'd3;
        en = 1'b1;
        tick();
        tick();
        check("racc_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("racc_outs", {busy, pert_stb, pert_sign, upd_valid, 28'd0} | 32'(j_plus)
              | 32'(j_minus) | 32'(delta_j) | iter_cnt, 32'd0);
        rst = 1'b0;
        en = 1'b0;
        tick();
        exp_iter = 0;

        // 1000 back-to-back minimal iterations
        settle_cyc = 16'd0; ave_log2 = 4'd0;
        set_pat(12'd1, 12'd1, 12'd2, 12'd2);
        upd_ready = 1'b1;
        en = 1'b1;
        c = 0; nv = 0;
        while (iter_cnt != 32'd1000 && c < 6000) begin
            tick();
            c++;
            if (upd_valid) nv++;
        end
        check("b2b_cycles", 32'(c), 32'd5001);
        check("b2b_valids", 32'(nv), 32'd1000);
        check("b2b_iter", iter_cnt, 32'd1000);
        check("b2b_dj", 32'(delta_j), 32'h1FFF);
        en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
